// File: rtl/vga_sram_arbiter.sv
// vga_sram_arbiter: shares one single-port SRAM between the VGA word fetcher and the CPU data bus
// Ports:
//   clk, nrst                      system clock, asynchronous active-low reset
//   vga_blank                      display blanking; CPU takes precedence while high
//   vga_req/addr, vga_ack/rdata    VGA read requester: level request, one-cycle ack, registered data
//   cpu_req/wen/addr/wdata/sel     CPU read/write requester: level request, stable until ack
//   cpu_ack/rdata                  CPU one-cycle completion pulse and registered read data
//   sram_read/write                one-cycle SRAM strobes
//   sram_addr/wdata/sel            SRAM address, write data, byte enables (held for the whole access)
//   sram_rdata                     SRAM read data, valid SRAM_LAT cycles after the read strobe
//   cpu_starve                     high while the CPU starvation counter is saturated
module vga_sram_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int SRAM_LAT     = 2,
    parameter int CPU_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              vga_blank,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [3:0]        cpu_sel,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              sram_read,
    output logic              sram_write,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic [3:0]        sram_sel,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              cpu_starve
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam logic [7:0] MAX_WAIT = 8'(CPU_MAX_WAIT);
    state_t      state;
    logic        grant_cpu;
    logic        wen;
    logic [3:0]  lat_cnt;
    logic [7:0]  starve_cnt;
    logic        cpu_wins;
    assign cpu_wins = cpu_req && (!vga_req || vga_blank || starve_cnt == MAX_WAIT);
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            grant_cpu  <= 1'b0;
            wen        <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            cpu_starve <= 1'b0;
            vga_ack    <= 1'b0;
            cpu_ack    <= 1'b0;
            vga_rdata  <= '0;
            cpu_rdata  <= '0;
            sram_read  <= 1'b0;
            sram_write <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_sel   <= '0;
        end else begin
            vga_ack    <= 1'b0;
            cpu_ack    <= 1'b0;
            sram_read  <= 1'b0;
            sram_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_wins) begin
                        grant_cpu  <= 1'b1;
                        wen        <= cpu_wen;
                        sram_addr  <= cpu_addr;
                        sram_wdata <= cpu_wdata;
                        sram_sel   <= cpu_sel;
                        sram_read  <= !cpu_wen;
                        sram_write <= cpu_wen;
                        starve_cnt <= '0;
                        cpu_starve <= 1'b0;
                        state      <= ISSUE;
                    end else if (vga_req) begin
                        grant_cpu  <= 1'b0;
                        wen        <= 1'b0;
                        sram_addr  <= vga_addr;
                        sram_wdata <= '0;
                        sram_sel   <= 4'hF;
                        sram_read  <= 1'b1;
                        state      <= ISSUE;
                        // A losing CPU here implies the counter is below its limit, so this saturates.
                        if (cpu_req) begin
                            starve_cnt <= starve_cnt + 8'd1;
                            cpu_starve <= (starve_cnt + 8'd1 == MAX_WAIT);
                        end
                    end
                end
                ISSUE: begin
                    if (wen) begin
                        cpu_ack <= 1'b1;
                        state   <= DONE;
                    end else begin
                        lat_cnt <= 4'(SRAM_LAT - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        if (grant_cpu) cpu_rdata <= sram_rdata;
                        else vga_rdata <= sram_rdata;
                        cpu_ack <= grant_cpu;
                        vga_ack <= !grant_cpu;
                        state   <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_sram_arbiter.sv
// tb_vga_sram_arbiter: directed and randomized checks of the VGA/CPU SRAM arbiter against a behavioural model
module tb_vga_sram_arbiter;
    localparam int LAT  = 2;
    localparam int MAXW = 2;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic        vga_blank = 1'b0, vga_req = 1'b0, cpu_req = 1'b0, cpu_wen = 1'b0;
    logic [31:0] vga_addr = '0, cpu_addr = '0, cpu_wdata = '0, sram_rdata = '0;
    logic [3:0]  cpu_sel = '0;
    logic        vga_ack, cpu_ack, sram_read, sram_write, cpu_starve;
    logic [31:0] vga_rdata, cpu_rdata, sram_addr, sram_wdata;
    logic [3:0]  sram_sel;

    logic        b_vga_req = 1'b0;
    logic [31:0] b_vga_addr = '0, b_sram_rdata = '0;
    logic        b_vga_ack, b_cpu_ack, b_sram_read, b_sram_write, b_cpu_starve;
    logic [31:0] b_vga_rdata, b_cpu_rdata, b_sram_addr, b_sram_wdata;
    logic [3:0]  b_sram_sel;

    vga_sram_arbiter #(.ADDR_W(32), .DATA_W(32), .SRAM_LAT(LAT), .CPU_MAX_WAIT(MAXW)) dut (
        .clk(clk), .nrst(nrst), .vga_blank(vga_blank), .vga_req(vga_req), .vga_addr(vga_addr),
        .vga_ack(vga_ack), .vga_rdata(vga_rdata), .cpu_req(cpu_req), .cpu_wen(cpu_wen),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_sel(cpu_sel), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata), .sram_read(sram_read), .sram_write(sram_write), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_sel(sram_sel), .sram_rdata(sram_rdata), .cpu_starve(cpu_starve)
    );

    vga_sram_arbiter #(.ADDR_W(32), .DATA_W(32), .SRAM_LAT(1), .CPU_MAX_WAIT(8)) dut_lat1 (
        .clk(clk), .nrst(nrst), .vga_blank(1'b0), .vga_req(b_vga_req), .vga_addr(b_vga_addr),
        .vga_ack(b_vga_ack), .vga_rdata(b_vga_rdata), .cpu_req(1'b0), .cpu_wen(1'b0),
        .cpu_addr(32'd0), .cpu_wdata(32'd0), .cpu_sel(4'd0), .cpu_ack(b_cpu_ack),
        .cpu_rdata(b_cpu_rdata), .sram_read(b_sram_read), .sram_write(b_sram_write), .sram_addr(b_sram_addr),
        .sram_wdata(b_sram_wdata), .sram_sel(b_sram_sel), .sram_rdata(b_sram_rdata), .cpu_starve(b_cpu_starve)
    );

    int          errs = 0;
    int          checks = 0;
    int          exp_cnt = 0;
    logic [31:0] exp_vr = '0, exp_cr = '0;
    logic [31:0] ref_mem [64];

    function automatic logic [31:0] init_word(input int i);
        return (i == 16) ? 32'hDEADBEEF : 32'hC0DE0000 + i * 32'h1011;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // SRAM model: memory contents and a read pipeline that shows data only in the cycle SRAM_LAT after the strobe.
    logic [31:0] smem [64];
    logic [63:0] smem_v = '0;
    int          rd_age = 99, b_age = 99;
    logic [5:0]  rd_addr = '0, b_addr = '0;

    function automatic logic [31:0] mem_word(input logic [5:0] a);
        return smem_v[a] ? smem[a] : init_word(int'(a));
    endfunction

    always @(negedge clk) begin
        if (sram_write) begin
            smem[sram_addr[5:0]]   <= merge(mem_word(sram_addr[5:0]), sram_wdata, sram_sel);
            smem_v[sram_addr[5:0]] <= 1'b1;
        end
        rd_age <= sram_read ? 0 : (rd_age < 99 ? rd_age + 1 : rd_age);
        if (sram_read) rd_addr <= sram_addr[5:0];
        sram_rdata <= (!sram_read && rd_age + 1 == LAT) ? mem_word(rd_addr) : $urandom;
        b_age <= b_sram_read ? 0 : (b_age < 99 ? b_age + 1 : b_age);
        if (b_sram_read) b_addr <= b_sram_addr[5:0];
        b_sram_rdata <= (!b_sram_read && b_age + 1 == 1) ? 32'hA0 + {26'd0, b_addr} : $urandom;
    end

    typedef struct {
        int          ack_cyc;
        int          strobe_cyc;
        int          nreads;
        int          nwrites;
        logic        vack;
        logic        cack;
        logic        starve;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic [3:0]  s_sel;
        logic [31:0] vr;
        logic [31:0] cr;
    } obs_t;

    // Steps negedges after the requests are driven and records strobes and the first ack.
    task automatic run_access(output obs_t o);
        o.ack_cyc = 0; o.strobe_cyc = 0; o.nreads = 0; o.nwrites = 0;
        o.vack = 1'b0; o.cack = 1'b0; o.starve = 1'b0;
        o.s_addr = '0; o.s_wdata = '0; o.s_sel = '0; o.vr = '0; o.cr = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (sram_read || sram_write) begin
                o.strobe_cyc = i;
                o.nreads += int'(sram_read);
                o.nwrites += int'(sram_write);
                o.s_addr = sram_addr;
                o.s_wdata = sram_wdata;
                o.s_sel = sram_sel;
            end
            if (vga_ack || cpu_ack) begin
                o.ack_cyc = i;
                o.vack = vga_ack;
                o.cack = cpu_ack;
                o.starve = cpu_starve;
                o.vr = vga_rdata;
                o.cr = cpu_rdata;
                return;
            end
        end
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({vga_ack, cpu_ack, sram_read, sram_write, cpu_starve, vga_rdata, cpu_rdata, sram_addr, sram_wdata, sram_sel,
             b_vga_ack, b_cpu_ack, b_sram_read, b_sram_write, b_cpu_starve, b_vga_rdata, b_cpu_rdata, b_sram_addr,
             b_sram_wdata, b_sram_sel} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got vga_ack=%b cpu_ack=%b rd=%b wr=%b starve=%b addr=%h required all zero",
                     vga_ack, cpu_ack, sram_read, sram_write, cpu_starve, sram_addr);
        end
        nrst = 1'b1;
    endtask

    task automatic test_vga_read;
        obs_t o;
        vga_addr = 32'h10;
        vga_req = 1'b1;
        run_access(o);
        vga_req = 1'b0;
        checks++;
        if ({o.nreads, o.nwrites, o.strobe_cyc} !== {32'd1, 32'd0, 32'd1}) begin
            errs++;
            $display("FAIL vga_strobe: got reads=%0d writes=%0d cyc=%0d required 1 0 1", o.nreads, o.nwrites, o.strobe_cyc);
        end
        checks++;
        if ({o.s_addr, o.s_sel} !== {32'h10, 4'hF}) begin
            errs++;
            $display("FAIL vga_addr_sel: got %h/%h required 00000010/f", o.s_addr, o.s_sel);
        end
        checks++;
        if (o.ack_cyc !== 2 + LAT) begin
            errs++;
            $display("FAIL vga_ack_cycle: got %0d required %0d", o.ack_cyc, 2 + LAT);
        end
        checks++;
        if ({o.vack, o.cack} !== 2'b10) begin
            errs++;
            $display("FAIL vga_ack_owner: got vga=%b cpu=%b required 1 0", o.vack, o.cack);
        end
        checks++;
        if (o.vr !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL vga_rdata: got %h required deadbeef", o.vr);
        end
        checks++;
        if (o.cr !== exp_cr) begin
            errs++;
            $display("FAIL vga_read_cpu_rdata: got %h required %h", o.cr, exp_cr);
        end
        exp_vr = 32'hDEADBEEF;
        @(negedge clk);
    endtask

    task automatic test_cpu_write;
        obs_t o;
        cpu_addr = 32'h20;
        cpu_wdata = 32'h12345678;
        cpu_sel = 4'h3;
        cpu_wen = 1'b1;
        cpu_req = 1'b1;
        run_access(o);
        cpu_req = 1'b0;
        checks++;
        if ({o.nreads, o.nwrites, o.strobe_cyc} !== {32'd0, 32'd1, 32'd1}) begin
            errs++;
            $display("FAIL cpu_write_strobe: got reads=%0d writes=%0d cyc=%0d required 0 1 1", o.nreads, o.nwrites, o.strobe_cyc);
        end
        checks++;
        if ({o.s_addr, o.s_wdata, o.s_sel} !== {32'h20, 32'h12345678, 4'h3}) begin
            errs++;
            $display("FAIL cpu_write_bus: got %h/%h/%h required 00000020/12345678/3", o.s_addr, o.s_wdata, o.s_sel);
        end
        checks++;
        if (o.ack_cyc !== 2) begin
            errs++;
            $display("FAIL cpu_write_ack_cycle: got %0d required 2", o.ack_cyc);
        end
        checks++;
        if ({o.vack, o.cack} !== 2'b01) begin
            errs++;
            $display("FAIL cpu_write_owner: got vga=%b cpu=%b required 0 1", o.vack, o.cack);
        end
        checks++;
        if ({o.vr, o.cr} !== {exp_vr, exp_cr}) begin
            errs++;
            $display("FAIL cpu_write_rdata_hold: got %h/%h required %h/%h", o.vr, o.cr, exp_vr, exp_cr);
        end
        ref_mem[32] = merge(ref_mem[32], 32'h12345678, 4'h3);
        cpu_wen = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait;
        obs_t o;
        vga_addr = 32'h11;
        vga_req = 1'b1;
        repeat (2) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({vga_ack, cpu_ack, sram_read, sram_write, cpu_starve, vga_rdata, cpu_rdata, sram_addr, sram_wdata, sram_sel} !== '0) begin
            errs++;
            $display("FAIL reset_in_wait: got addr=%h sel=%h vga_rdata=%h required all zero", sram_addr, sram_sel, vga_rdata);
        end
        @(negedge clk);
        checks++;
        if (vga_ack !== 1'b0) begin
            errs++;
            $display("FAIL reset_no_ack: got %b required 0", vga_ack);
        end
        exp_vr = '0;
        exp_cr = '0;
        exp_cnt = 0;
        nrst = 1'b1;
        run_access(o);
        vga_req = 1'b0;
        checks++;
        if (o.ack_cyc !== 2 + LAT) begin
            errs++;
            $display("FAIL post_reset_ack_cycle: got %0d required %0d", o.ack_cyc, 2 + LAT);
        end
        checks++;
        if ({o.vack, o.cack, o.nreads} !== {2'b10, 32'd1}) begin
            errs++;
            $display("FAIL post_reset_owner: got vga=%b cpu=%b reads=%0d required 1 0 1", o.vack, o.cack, o.nreads);
        end
        checks++;
        if ({o.vr, o.cr} !== {ref_mem[17], 32'h0}) begin
            errs++;
            $display("FAIL post_reset_rdata: got %h/%h required %h/00000000", o.vr, o.cr, ref_mem[17]);
        end
        exp_vr = ref_mem[17];
        @(negedge clk);
    endtask

    task automatic test_starvation;
        obs_t o;
        logic win_cpu;
        vga_addr = 32'h12;
        cpu_addr = 32'h30;
        cpu_wen = 1'b1;
        cpu_wdata = $urandom;
        cpu_sel = 4'hF;
        vga_req = 1'b1;
        cpu_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            win_cpu = (k == 2);
            run_access(o);
            checks++;
            if ({o.vack, o.cack} !== (win_cpu ? 2'b01 : 2'b10)) begin
                errs++;
                $display("FAIL starve_order[%0d]: got vga=%b cpu=%b required cpu=%b", k, o.vack, o.cack, win_cpu);
            end
            checks++;
            if (o.starve !== (k == 1)) begin
                errs++;
                $display("FAIL starve_flag[%0d]: got %b required %b", k, o.starve, k == 1);
            end
            checks++;
            if (o.ack_cyc !== (win_cpu ? 2 : 2 + LAT) + (k > 0 ? 1 : 0)) begin
                errs++;
                $display("FAIL starve_ack_cycle[%0d]: got %0d", k, o.ack_cyc);
            end
            if (win_cpu) ref_mem[48] = merge(ref_mem[48], cpu_wdata, 4'hF);
            else exp_vr = ref_mem[18];
            exp_cnt = win_cpu ? 0 : exp_cnt + 1;
        end
        checks++;
        if (o.vr !== ref_mem[18]) begin
            errs++;
            $display("FAIL starve_vga_rdata: got %h required %h", o.vr, ref_mem[18]);
        end
        vga_req = 1'b0;
        cpu_req = 1'b0;
        cpu_wen = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_blank;
        obs_t o;
        vga_blank = 1'b1;
        cpu_addr = 32'h13;
        cpu_wen = 1'b0;
        vga_addr = 32'h14;
        vga_req = 1'b1;
        cpu_req = 1'b1;
        run_access(o);
        cpu_req = 1'b0;
        checks++;
        if ({o.vack, o.cack} !== 2'b01) begin
            errs++;
            $display("FAIL blank_cpu_first: got vga=%b cpu=%b required 0 1", o.vack, o.cack);
        end
        checks++;
        if (o.ack_cyc !== 2 + LAT) begin
            errs++;
            $display("FAIL blank_cpu_ack_cycle: got %0d required %0d", o.ack_cyc, 2 + LAT);
        end
        checks++;
        if ({o.vr, o.cr} !== {exp_vr, ref_mem[19]}) begin
            errs++;
            $display("FAIL blank_cpu_rdata: got %h/%h required %h/%h", o.vr, o.cr, exp_vr, ref_mem[19]);
        end
        exp_cr = ref_mem[19];
        exp_cnt = 0;
        run_access(o);
        vga_req = 1'b0;
        checks++;
        if ({o.vack, o.cack} !== 2'b10) begin
            errs++;
            $display("FAIL blank_vga_second: got vga=%b cpu=%b required 1 0", o.vack, o.cack);
        end
        checks++;
        if (o.ack_cyc !== 3 + LAT) begin
            errs++;
            $display("FAIL blank_vga_ack_cycle: got %0d required %0d", o.ack_cyc, 3 + LAT);
        end
        checks++;
        if ({o.vr, o.cr} !== {ref_mem[20], exp_cr}) begin
            errs++;
            $display("FAIL blank_vga_rdata: got %h/%h required %h/%h", o.vr, o.cr, ref_mem[20], exp_cr);
        end
        exp_vr = ref_mem[20];
        vga_blank = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n = 0;
        b_vga_addr = 32'd0;
        b_vga_req = 1'b1;
        for (int i = 1; i <= 40 && n < 4; i++) begin
            @(negedge clk);
            if (b_vga_ack) begin
                checks++;
                if (i !== 3 + 4 * n) begin
                    errs++;
                    $display("FAIL b2b_ack_cycle[%0d]: got %0d required %0d", n, i, 3 + 4 * n);
                end
                checks++;
                if (b_vga_rdata !== 32'hA0 + n) begin
                    errs++;
                    $display("FAIL b2b_rdata[%0d]: got %h required %h", n, b_vga_rdata, 32'hA0 + n);
                end
                n++;
                b_vga_addr = n;
            end
        end
        b_vga_req = 1'b0;
        checks++;
        if (n !== 4) begin
            errs++;
            $display("FAIL b2b_count: got %0d acks required 4", n);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        obs_t        o;
        logic        v, c, win_cpu, wr;
        logic [5:0]  a;
        logic [31:0] d;
        int          off;
        for (int r = 0; r < 60; r++) begin
            off = (r == 0) ? 0 : 1;
            v = ($urandom % 4) != 0;
            c = v ? 1'($urandom % 2) : 1'b1;
            vga_blank = ($urandom % 6) == 0;
            vga_addr = $urandom % 64;
            cpu_addr = $urandom % 64;
            cpu_wen = 1'($urandom % 2);
            cpu_wdata = $urandom;
            cpu_sel = 4'($urandom % 16);
            vga_req = v;
            cpu_req = c;
            win_cpu = c && (!v || vga_blank || exp_cnt == MAXW);
            exp_cnt = win_cpu ? 0 : (c ? exp_cnt + 1 : exp_cnt);
            wr = win_cpu && cpu_wen;
            a = win_cpu ? cpu_addr[5:0] : vga_addr[5:0];
            run_access(o);
            checks++;
            if ({o.vack, o.cack} !== (win_cpu ? 2'b01 : 2'b10)) begin
                errs++;
                $display("FAIL rnd_owner[%0d]: got vga=%b cpu=%b required cpu=%b", r, o.vack, o.cack, win_cpu);
            end
            checks++;
            if (o.ack_cyc !== (wr ? 2 : 2 + LAT) + off) begin
                errs++;
                $display("FAIL rnd_ack_cycle[%0d]: got %0d required %0d", r, o.ack_cyc, (wr ? 2 : 2 + LAT) + off);
            end
            checks++;
            if ({o.nreads, o.nwrites, o.strobe_cyc} !== {wr ? 32'd0 : 32'd1, wr ? 32'd1 : 32'd0, 32'(1 + off)}) begin
                errs++;
                $display("FAIL rnd_strobe[%0d]: got reads=%0d writes=%0d cyc=%0d", r, o.nreads, o.nwrites, o.strobe_cyc);
            end
            checks++;
            if ({o.s_addr, o.s_sel} !== {26'd0, a, win_cpu ? cpu_sel : 4'hF}) begin
                errs++;
                $display("FAIL rnd_addr_sel[%0d]: got %h/%h required %h/%h", r, o.s_addr, o.s_sel, a, win_cpu ? cpu_sel : 4'hF);
            end
            checks++;
            if (o.starve !== (exp_cnt == MAXW)) begin
                errs++;
                $display("FAIL rnd_starve[%0d]: got %b required %b", r, o.starve, exp_cnt == MAXW);
            end
            if (wr) begin
                checks++;
                if (o.s_wdata !== cpu_wdata) begin
                    errs++;
                    $display("FAIL rnd_wdata[%0d]: got %h required %h", r, o.s_wdata, cpu_wdata);
                end
                ref_mem[a] = merge(ref_mem[a], cpu_wdata, cpu_sel);
            end else begin
                d = ref_mem[a];
                if (win_cpu) exp_cr = d;
                else exp_vr = d;
            end
            checks++;
            if ({o.vr, o.cr} !== {exp_vr, exp_cr}) begin
                errs++;
                $display("FAIL rnd_rdata[%0d]: got %h/%h required %h/%h", r, o.vr, o.cr, exp_vr, exp_cr);
            end
        end
        vga_req = 1'b0;
        cpu_req = 1'b0;
        vga_blank = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        test_reset;
        test_vga_read;
        test_cpu_write;
        test_reset_in_wait;
        test_starvation;
        test_blank;
        test_back_to_back;
        test_random;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vga_sram_arbiter.md
Name: vga_sram_arbiter

Overview:
Arbitrates the single-port pixel/data SRAM between two requesters: the VGA word fetcher (read-only, display-critical) and the CPU data bus (read/write). Sits between both masters and the SRAM port. Only one access is in flight at a time. VGA has priority except during blanking or when the CPU has hit its starvation limit.

Parameters:
ADDR_W, 32, width of the word address on all ports
DATA_W, 32, width of the data word
SRAM_LAT, 2, cycles from the read-strobe cycle to the cycle where sram_rdata is valid (legal range 1..15)
CPU_MAX_WAIT, 8, cycles a pending CPU request may lose arbitration before it is forced to win (legal range 1..255)

Ports:
clk  in  1  system clock
nrst  in  1  async active-low reset
vga_blank  in  1  high during horizontal/vertical blanking
vga_req  in  1  VGA read request; level, held until vga_ack
vga_addr  in  ADDR_W  VGA word address; stable while vga_req is high
vga_ack  out  1  one-cycle pulse; vga_rdata is valid in this cycle
vga_rdata  out  DATA_W  registered read data for VGA
cpu_req  in  1  CPU request; level, held until cpu_ack
cpu_wen  in  1  1 = write, 0 = read; stable while cpu_req is high
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_sel  in  4  CPU byte enables
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  registered read data for CPU
sram_read  out  1  one-cycle read strobe
sram_write  out  1  one-cycle write strobe
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_sel  out  4  SRAM byte enables
sram_rdata  in  DATA_W  SRAM read data
cpu_starve  out  1  high while the starvation counter equals CPU_MAX_WAIT

Behaviour:
- Reset (async, any state): state IDLE; every output 0, including rdata registers and sram_addr/wdata/sel. The starvation counter and latency counter clear. Any in-flight access is dropped with no ack.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE. A grant register records the owner (VGA or CPU).
- IDLE: samples requests.
  - cpu_req wins if vga_req=0, or vga_blank=1, or the starvation counter equals CPU_MAX_WAIT.
  - Otherwise vga_req wins.
  - On a win: latch owner, address, wdata, sel (VGA sel = 4'hF) into sram_* and go to ISSUE.
- ISSUE (1 cycle): sram_read=1 for a read, sram_write=1 for a CPU write; the strobe is high only in this cycle.
  - A write goes to DONE next.
  - A read goes to WAIT with the latency counter loaded to SRAM_LAT-1.
- WAIT: hold sram_addr/sel/wdata stable and decrement the counter. At count 0, capture sram_rdata into the owner's rdata register and go to DONE.
  - The non-owner's rdata register is unchanged.
- DONE (1 cycle): the owner's ack=1. Requests are not sampled in DONE, so the requester can drop req or present a new address. Next state is IDLE.
- Access timing, with request accepted in IDLE at cycle 0:
  - Read: strobe in cycle 1, data sampled in cycle 1+SRAM_LAT, ack in cycle 2+SRAM_LAT.
  - Write: strobe in cycle 1, ack in cycle 2.
- Starvation counter (8-bit):
  - Increments, saturating at CPU_MAX_WAIT, on each IDLE cycle where cpu_req=1 and VGA is granted.
  - Clears when the CPU is granted.
  - Holds otherwise.
- Simultaneous vga_req and cpu_req with blank=0 and counter below max: VGA wins.
- A request dropped before its ack is a protocol violation. The access still completes and ack still pulses.
- A request raised in the DONE cycle is seen in the next IDLE cycle. Back-to-back throughput is one access per SRAM_LAT+3 cycles (read) or 3 cycles (write).

Test Plan:
- Lone VGA read, vga_addr=0x10, SRAM returns 0xDEADBEEF, SRAM_LAT=2 -> sram_read pulses at cycle 1 with sram_addr=0x10, sram_sel=F; vga_ack pulses at cycle 4 with vga_rdata=0xDEADBEEF; cpu_ack stays 0.
- CPU write, addr=0x20, wdata=0x12345678, sel=0x3 -> sram_write pulses for 1 cycle with matching addr/wdata/sel; cpu_ack at cycle 2; sram_read never asserted.
- vga_req and cpu_req both held high, blank=0, CPU_MAX_WAIT=2 -> the sequence is VGA, VGA, CPU (cpu_starve high before the CPU grant, low after), then VGA again.
- Same both-request stimulus with vga_blank=1 -> CPU is granted first; VGA is served after cpu_ack.
- nrst pulsed low in WAIT of a VGA read -> all outputs 0 immediately, no vga_ack. After release with vga_req still high, a fresh read completes with the correct data.
- SRAM_LAT=1, 4 back-to-back VGA reads at addr 0..3 returning 0xA0..0xA3 -> acks 4 cycles apart with the data in order.
